// File: rtl/nrisc_pc_stack_ctrl_pkg.sv
// nrisc_pc_stack_ctrl_pkg: shared constants, pc_op and FSM encodings for the PC/stack controller.
package nrisc_pc_stack_ctrl_pkg;
  localparam int TAM_DEF          = 16;
  localparam int N_IDATA          = 16;
  localparam int ADDR_W_DEF       = 10;
  localparam int STACK_DEPTH_DEF  = 16;
  localparam int N_IRQ_DEF        = 8;
  localparam int IRQ_BASE_DEF     = 0;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam bit HALT_ON_ERR_DEF  = 1'b1;
  localparam logic [N_IDATA-1:0] NOP = '0;
  typedef enum logic [1:0] {OP_SEQ = 2'b00, OP_JMP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11} pc_op_e;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_HALT = 2'd2} state_e;
endpackage

// File: rtl/nrisc_ret_stack.sv
// nrisc_ret_stack: LIFO of return addresses; top reads 0 when empty.
module nrisc_ret_stack #(
  parameter int DEPTH = 16,
  parameter int W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [W-1:0]             o_top,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_cnt;
  logic [AW-1:0] w_idx;
  assign o_full = r_cnt == FULL;
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign w_idx = AW'(r_cnt - 1'b1);
  assign o_top = o_empty ? '0 : r_mem[w_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_push && !o_full) r_cnt <= r_cnt + 1'b1;
    else if (i_pop && !o_empty) r_cnt <= r_cnt - 1'b1;
  // contents need no reset: entries are only read below the count
  always_ff @(posedge clk)
    if (i_push && !o_full) r_mem[r_cnt[AW-1:0]] <= i_data;
endmodule

// File: rtl/nrisc_pc_stack_ctrl.sv
// nrisc_pc_stack_ctrl: program counter, return stack, interrupt entry/exit and fetch-flush control.
module nrisc_pc_stack_ctrl
  import nrisc_pc_stack_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int TAM          = TAM_DEF,
  parameter int STACK_DEPTH  = STACK_DEPTH_DEF,
  parameter int N_IRQ        = N_IRQ_DEF,
  parameter int IRQ_BASE     = IRQ_BASE_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter bit HALT_ON_ERR  = HALT_ON_ERR_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_IDATA-1:0]            i_imem_data,
  output logic [ADDR_W-1:0]             o_imem_addr,
  output logic                          o_imem_en,
  output logic [N_IDATA-1:0]            o_instr_out,
  input  logic [1:0]                    i_pc_op,
  input  logic [ADDR_W-1:0]             i_tgt_addr,
  input  logic                          i_stall,
  input  logic [N_IRQ-1:0]              i_irq_req,
  input  logic                          i_irq_en,
  input  logic                          i_reti,
  output logic [N_IRQ-1:0]              o_irq_ack,
  output logic                          o_in_isr,
  output logic [TAM-1:0]                o_link_out,
  output logic [$clog2(STACK_DEPTH):0]  o_sp,
  output logic                          o_stk_ovf,
  output logic                          o_stk_unf,
  input  logic                          i_err_clr
);
  localparam logic [1:0] FL_LAST = 2'(FLUSH_CYCLES - 1);
  state_e r_state, w_nxt_state;
  pc_op_e w_op;
  logic [ADDR_W-1:0] r_pc, w_nxt_pc, w_vec, w_push_data, w_top;
  logic [1:0] r_cnt, w_nxt_cnt;
  logic r_isr, w_nxt_isr, r_ovf, w_nxt_ovf, r_unf, w_nxt_unf;
  logic [N_IRQ-1:0] r_ack, w_nxt_ack, w_irq_low;
  logic w_go, w_irq, w_push_req, w_pop_req, w_full, w_empty, w_push, w_pop;

  assign w_op = pc_op_e'(i_pc_op);
  assign w_go = r_state == ST_RUN && !i_stall;
  assign w_irq = i_irq_en && !r_isr && |i_irq_req;
  assign w_irq_low = i_irq_req & (~i_irq_req + N_IRQ'(1));
  // reti outranks pc_op, the interrupt outranks both
  assign w_push_req = w_irq || (!i_reti && w_op == OP_CALL);
  assign w_pop_req = !w_irq && (i_reti || w_op == OP_RET);
  assign w_push = w_go && w_push_req && !w_full;
  assign w_pop = w_go && w_pop_req && !w_empty;
  assign w_push_data = w_irq ? r_pc : r_pc + ADDR_W'(1);

  always_comb begin
    w_vec = ADDR_W'(IRQ_BASE);
    for (int k = 0; k < N_IRQ; k++)
      if (w_irq_low[k]) w_vec = ADDR_W'(IRQ_BASE + k);
  end

  nrisc_ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_top   (w_top),
    .o_count (o_sp)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc = r_pc;
    w_nxt_cnt = r_cnt;
    w_nxt_isr = r_isr;
    w_nxt_ack = '0;
    w_nxt_ovf = r_ovf;
    w_nxt_unf = r_unf;
    if (!i_stall) begin
      if (i_err_clr) begin
        w_nxt_ovf = 1'b0;
        w_nxt_unf = 1'b0;
      end
      case (r_state)
        ST_HALT: if (i_err_clr) w_nxt_state = ST_RUN;
        ST_FLUSH: begin
          w_nxt_cnt = r_cnt == FL_LAST ? 2'd0 : r_cnt + 2'd1;
          if (r_cnt == FL_LAST) w_nxt_state = ST_RUN;
        end
        default: begin
          if ((w_push_req && w_full) || (w_pop_req && w_empty)) begin
            if (w_push_req) w_nxt_ovf = 1'b1;
            if (w_pop_req) w_nxt_unf = 1'b1;
            if (HALT_ON_ERR) w_nxt_state = ST_HALT;
            else w_nxt_pc = r_pc + ADDR_W'(1);
          end else if (w_push_req || w_pop_req || w_op == OP_JMP) begin
            w_nxt_state = ST_FLUSH;
            w_nxt_cnt = 2'd0;
            w_nxt_pc = w_irq ? w_vec : w_pop_req ? w_top : i_tgt_addr;
            if (w_irq) w_nxt_isr = 1'b1;
            if (w_irq) w_nxt_ack = w_irq_low;
            if (w_pop_req && i_reti) w_nxt_isr = 1'b0;
          end else w_nxt_pc = r_pc + ADDR_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc <= '0;
      r_cnt <= '0;
      r_isr <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_ack <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_pc <= w_nxt_pc;
      r_cnt <= w_nxt_cnt;
      r_isr <= w_nxt_isr;
      r_ovf <= w_nxt_ovf;
      r_unf <= w_nxt_unf;
      r_ack <= w_nxt_ack;
    end

  assign o_imem_addr = r_pc;
  assign o_imem_en = w_go;
  assign o_instr_out = w_go ? i_imem_data : NOP;
  assign o_irq_ack = r_ack;
  assign o_in_isr = r_isr;
  assign o_link_out = TAM'(w_top);
  assign o_stk_ovf = r_ovf;
  assign o_stk_unf = r_unf;
endmodule

// File: tb/tb_nrisc_pc_stack_ctrl.sv
// tb_nrisc_pc_stack_ctrl: directed scenarios plus randomized run against a queue-based behavioural model.
module tb_nrisc_pc_stack_ctrl;
  localparam int DEPTH = 16;
  localparam int FLUSH = 2;
  localparam int IRQ_BASE = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] imem_data, instr_out, link_out;
  logic [9:0] imem_addr, tgt;
  logic imem_en, stall, irq_en, reti, in_isr, stk_ovf, stk_unf, err_clr;
  logic [1:0] pc_op;
  logic [7:0] irq_req, irq_ack;
  logic [4:0] sp;
  int n_cmp = 0;
  int n_bad = 0;
  int m_pc, m_mode, m_fl, m_ack;
  int m_stk[$];
  bit m_isr, m_ovf, m_unf;

  always #5 clk = ~clk;
  assign imem_data = 16'hA000 | 16'(imem_addr);

  nrisc_pc_stack_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_imem_data (imem_data),
    .o_imem_addr (imem_addr),
    .o_imem_en   (imem_en),
    .o_instr_out (instr_out),
    .i_pc_op     (pc_op),
    .i_tgt_addr  (tgt),
    .i_stall     (stall),
    .i_irq_req   (irq_req),
    .i_irq_en    (irq_en),
    .i_reti      (reti),
    .o_irq_ack   (irq_ack),
    .o_in_isr    (in_isr),
    .o_link_out  (link_out),
    .o_sp        (sp),
    .o_stk_ovf   (stk_ovf),
    .o_stk_unf   (stk_unf),
    .i_err_clr   (err_clr)
  );

  // mode: 0 run, 1 flush (m_fl cycles left), 2 halt
  task model_reset;
    m_pc = 0; m_mode = 0; m_fl = 0; m_ack = 0;
    m_isr = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  task model_step;
    int k;
    bit err;
    m_ack = 0;
    if (stall) return;
    if (err_clr) begin m_ovf = 0; m_unf = 0; end
    if (m_mode == 2) begin if (err_clr) m_mode = 0; return; end
    if (m_mode == 1) begin m_fl--; if (m_fl == 0) m_mode = 0; return; end
    err = 0;
    if (irq_en && !m_isr && irq_req != 0) begin
      k = 0;
      while (!irq_req[k]) k++;
      if (m_stk.size() == DEPTH) begin m_ovf = 1; err = 1; end
      else begin
        m_stk.push_back(m_pc); m_pc = IRQ_BASE + k; m_ack = 1 << k; m_isr = 1;
        m_mode = 1; m_fl = FLUSH;
      end
    end else if (reti || pc_op == 2'b11) begin
      if (m_stk.size() == 0) begin m_unf = 1; err = 1; end
      else begin
        m_pc = m_stk.pop_back();
        if (reti) m_isr = 0;
        m_mode = 1; m_fl = FLUSH;
      end
    end else if (pc_op == 2'b10) begin
      if (m_stk.size() == DEPTH) begin m_ovf = 1; err = 1; end
      else begin
        m_stk.push_back((m_pc + 1) % 1024); m_pc = tgt;
        m_mode = 1; m_fl = FLUSH;
      end
    end else if (pc_op == 2'b01) begin
      m_pc = tgt; m_mode = 1; m_fl = FLUSH;
    end else m_pc = (m_pc + 1) % 1024;
    if (err) m_mode = 2;
  endtask

  task cyc;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task idle_inputs;
    pc_op = 2'b00; tgt = '0; stall = 0; irq_req = '0; irq_en = 0; reti = 0; err_clr = 0;
  endtask

  task do_reset;
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task test_reset;
    do_reset();
    n_cmp++;
    if ({imem_addr, imem_en, sp, in_isr, stk_ovf, stk_unf, irq_ack, link_out} !==
        {10'd0, 1'b1, 5'd0, 3'b000, 8'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_state: got addr=%h en=%b sp=%0d isr=%b ovf=%b unf=%b ack=%h link=%h, want all idle/0 with en=1",
               imem_addr, imem_en, sp, in_isr, stk_ovf, stk_unf, irq_ack, link_out);
    end
  endtask

  task test_sequential;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({imem_addr, imem_en, instr_out} !== {10'(i), 1'b1, 16'hA000 | 16'(i)}) begin
        n_bad++;
        $display("FAIL seq_fetch[%0d]: got addr=%h en=%b instr=%h, want addr=%h en=1 instr=%h",
                 i, imem_addr, imem_en, instr_out, 10'(i), 16'hA000 | 16'(i));
      end
      cyc();
    end
  endtask

  task test_call_return;
    do_reset();
    repeat (5) cyc();
    pc_op = 2'b10; tgt = 10'h40; cyc(); pc_op = 2'b00;
    n_cmp++;
    if ({sp, link_out, imem_addr, imem_en, instr_out} !== {5'd1, 16'd6, 10'h40, 1'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL call_entry: got sp=%0d link=%h addr=%h en=%b instr=%h, want sp=1 link=6 addr=40 en=0 instr=0",
               sp, link_out, imem_addr, imem_en, instr_out);
    end
    cyc();
    n_cmp++;
    if ({imem_en, instr_out, imem_addr} !== {1'b0, 16'h0, 10'h40}) begin
      n_bad++;
      $display("FAIL call_flush2: got en=%b instr=%h addr=%h, want en=0 instr=0 addr=40", imem_en, instr_out, imem_addr);
    end
    cyc();
    n_cmp++;
    if ({imem_en, instr_out, imem_addr} !== {1'b1, 16'hA040, 10'h40}) begin
      n_bad++;
      $display("FAIL call_fetch: got en=%b instr=%h addr=%h, want en=1 instr=a040 addr=40", imem_en, instr_out, imem_addr);
    end
    pc_op = 2'b11; cyc(); pc_op = 2'b00;
    n_cmp++;
    if ({sp, link_out, imem_addr, imem_en} !== {5'd0, 16'd0, 10'd6, 1'b0}) begin
      n_bad++;
      $display("FAIL return_entry: got sp=%0d link=%h addr=%h en=%b, want sp=0 link=0 addr=6 en=0", sp, link_out, imem_addr, imem_en);
    end
    cyc(); cyc();
    n_cmp++;
    if ({imem_addr, imem_en, instr_out} !== {10'd6, 1'b1, 16'hA006}) begin
      n_bad++;
      $display("FAIL return_fetch: got addr=%h en=%b instr=%h, want addr=6 en=1 instr=a006", imem_addr, imem_en, instr_out);
    end
  endtask

  task test_irq;
    do_reset();
    pc_op = 2'b01; tgt = 10'h10; cyc(); pc_op = 2'b00;
    cyc(); cyc();
    n_cmp++;
    if ({imem_addr, imem_en} !== {10'h10, 1'b1}) begin
      n_bad++;
      $display("FAIL jump_fetch: got addr=%h en=%b, want addr=10 en=1", imem_addr, imem_en);
    end
    irq_en = 1; irq_req = 8'b0010_0100; cyc(); irq_req = '0;
    n_cmp++;
    if ({irq_ack, imem_addr, in_isr, sp, link_out} !== {8'b0000_0100, 10'(IRQ_BASE + 2), 1'b1, 5'd1, 16'h10}) begin
      n_bad++;
      $display("FAIL irq_entry: got ack=%b addr=%h isr=%b sp=%0d link=%h, want ack=00000100 addr=2 isr=1 sp=1 link=10",
               irq_ack, imem_addr, in_isr, sp, link_out);
    end
    cyc();
    n_cmp++;
    if ({irq_ack, in_isr} !== {8'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL irq_ack_pulse: got ack=%b isr=%b, want ack=0 isr=1", irq_ack, in_isr);
    end
    cyc(); cyc();
    reti = 1; cyc(); reti = 0;
    n_cmp++;
    if ({imem_addr, in_isr, sp} !== {10'h10, 1'b0, 5'd0}) begin
      n_bad++;
      $display("FAIL reti: got addr=%h isr=%b sp=%0d, want addr=10 isr=0 sp=0", imem_addr, in_isr, sp);
    end
  endtask

  task test_overflow;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pc_op = 2'b10; tgt = 10'h100 + 10'(i); cyc(); pc_op = 2'b00;
      cyc(); cyc();
    end
    n_cmp++;
    if ({sp, link_out, imem_addr} !== {5'd16, 16'h10F, 10'h10F}) begin
      n_bad++;
      $display("FAIL stack_full: got sp=%0d link=%h addr=%h, want sp=16 link=10f addr=10f", sp, link_out, imem_addr);
    end
    pc_op = 2'b10; tgt = 10'h200; cyc(); pc_op = 2'b00;
    n_cmp++;
    if ({stk_ovf, imem_en, instr_out, sp, imem_addr} !== {1'b1, 1'b0, 16'h0, 5'd16, 10'h10F}) begin
      n_bad++;
      $display("FAIL overflow: got ovf=%b en=%b instr=%h sp=%0d addr=%h, want ovf=1 en=0 instr=0 sp=16 addr=10f",
               stk_ovf, imem_en, instr_out, sp, imem_addr);
    end
    repeat (3) cyc();
    n_cmp++;
    if ({stk_ovf, imem_en} !== 2'b10) begin
      n_bad++;
      $display("FAIL halt_hold: got ovf=%b en=%b, want ovf=1 en=0", stk_ovf, imem_en);
    end
    err_clr = 1; cyc(); err_clr = 0;
    n_cmp++;
    if ({stk_ovf, imem_en, imem_addr} !== {1'b0, 1'b1, 10'h10F}) begin
      n_bad++;
      $display("FAIL err_clr_ovf: got ovf=%b en=%b addr=%h, want ovf=0 en=1 addr=10f", stk_ovf, imem_en, imem_addr);
    end
  endtask

  task test_underflow;
    do_reset();
    pc_op = 2'b11; err_clr = 1; cyc(); pc_op = 2'b00; err_clr = 0;
    n_cmp++;
    if ({stk_unf, imem_en, imem_addr, sp} !== {1'b1, 1'b0, 10'd0, 5'd0}) begin
      n_bad++;
      $display("FAIL underflow_vs_clr: got unf=%b en=%b addr=%h sp=%0d, want unf=1 en=0 addr=0 sp=0", stk_unf, imem_en, imem_addr, sp);
    end
    err_clr = 1; cyc(); err_clr = 0;
    n_cmp++;
    if ({stk_unf, imem_en} !== 2'b01) begin
      n_bad++;
      $display("FAIL err_clr_unf: got unf=%b en=%b, want unf=0 en=1", stk_unf, imem_en);
    end
  endtask

  task test_reset_mid_flush;
    do_reset();
    irq_en = 1; irq_req = 8'h01; cyc(); irq_req = '0; irq_en = 0;
    n_cmp++;
    if ({in_isr, imem_en, irq_ack} !== {1'b1, 1'b0, 8'h01}) begin
      n_bad++;
      $display("FAIL pre_reset_isr: got isr=%b en=%b ack=%h, want isr=1 en=0 ack=01", in_isr, imem_en, irq_ack);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({imem_addr, imem_en, in_isr, sp, link_out, irq_ack, stk_ovf, stk_unf} !==
        {10'd0, 1'b1, 1'b0, 5'd0, 16'd0, 8'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL async_reset: got addr=%h en=%b isr=%b sp=%0d link=%h ack=%h ovf=%b unf=%b, want reset values",
               imem_addr, imem_en, in_isr, sp, link_out, irq_ack, stk_ovf, stk_unf);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc();
    n_cmp++;
    if ({imem_addr, imem_en} !== {10'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL resume_after_reset: got addr=%h en=%b, want addr=1 en=1", imem_addr, imem_en);
    end
  endtask

  task test_random;
    logic [58:0] exp_v, got_v;
    bit exp_en;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pc_op = 2'($urandom_range(0, 3));
      tgt = 10'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      irq_en = 1'($urandom_range(0, 1));
      irq_req = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h0;
      reti = ($urandom_range(0, 9) == 0);
      err_clr = ($urandom_range(0, 11) == 0);
      #1;
      exp_en = (m_mode == 0) && !stall;
      exp_v = {10'(m_pc), exp_en, exp_en ? (16'hA000 | 16'(m_pc)) : 16'h0, 5'(m_stk.size()),
               m_isr, m_ovf, m_unf, 8'(m_ack), (m_stk.size() != 0) ? 16'(m_stk[$]) : 16'h0};
      got_v = {imem_addr, imem_en, instr_out, sp, in_isr, stk_ovf, stk_unf, irq_ack, link_out};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL random[%0d]: got {addr,en,instr,sp,isr,ovf,unf,ack,link}=%h, want %h", i, got_v, exp_v);
      end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_call_return();
    test_irq();
    test_overflow();
    test_underflow();
    test_reset_mid_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nrisc_pc_stack_ctrl.md
NRISC_PC_STACK_CTRL -- requirements
Module: nrisc_pc_stack_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: instruction-memory address width.
REQ-002 Parameter TAM, default 16: core register width, with TAM >= ADDR_W.
REQ-003 Parameter STACK_DEPTH, default 16: return-stack entries, power of two, >= 2.
REQ-004 Parameter N_IRQ, default 8: interrupt channel count, 1..16.
REQ-005 Parameter IRQ_BASE, default 0: vector base address; channel k vectors to IRQ_BASE+k.
REQ-006 Parameter FLUSH_CYCLES, default 2: NOP cycles after any redirect, 1..3.
REQ-007 Parameter HALT_ON_ERR, default 1: stack error halts fetch.
REQ-008 clk  in  1  sole clock; all state on posedge.
REQ-009 rst  in  1  reset, asynchronous assert, active-low.
REQ-010 imem_data  in  16  fetched instruction word.
REQ-011 imem_addr  out  ADDR_W  fetch address, equal to the PC register.
REQ-012 imem_en  out  1  fetch enable; low during FLUSH, HALT and stall.
REQ-013 instr_out  out  16  instruction to core; imem_data when in RUN and not stalled, else 16'h0000 (NOP).
REQ-014 pc_op  in  2  00 sequential, 01 jump, 10 call, 11 return.
REQ-015 tgt_addr  in  ADDR_W  jump/call target, from ULA.
REQ-016 stall  in  1  freeze PC, stack and FSM.
REQ-017 irq_req  in  N_IRQ  level-sensitive requests.
REQ-018 irq_en  in  1  global interrupt enable.
REQ-019 reti  in  1  return from interrupt; overrides pc_op.
REQ-020 irq_ack  out  N_IRQ  one-hot single-cycle pulse on entry.
REQ-021 in_isr  out  1  high from interrupt entry until reti.
REQ-022 link_out  out  TAM  zero-extended top-of-stack entry; 0 when empty.
REQ-023 sp  out  clog2(STACK_DEPTH)+1  occupied entry count.
REQ-024 stk_ovf, stk_unf  out  1 each  sticky error flags.
REQ-025 err_clr  in  1  clears both error flags and leaves HALT to RUN.

Function
REQ-026 FSM states: RUN, FLUSH, HALT; FLUSH counter counts FLUSH_CYCLES then returns to RUN.
REQ-027 Event priority per cycle, taken only in RUN with stall low: interrupt > reti > return > call > jump > sequential.
REQ-028 Interrupt taken when irq_en=1, in_isr=0 and any irq_req bit set; lowest index wins.
REQ-029 Interrupt entry: push PC; set PC=IRQ_BASE+k; pulse irq_ack[k]; set in_isr; enter FLUSH.
REQ-030 Sequential: PC<=PC+1, wrapping modulo 2^ADDR_W.
REQ-031 Jump: PC<=tgt_addr; enter FLUSH.
REQ-032 Call: push PC+1 (modulo 2^ADDR_W), then PC<=tgt_addr; enter FLUSH.
REQ-033 Return and reti: PC<=popped entry; reti also clears in_isr; both enter FLUSH.
REQ-034 Push when sp==STACK_DEPTH: no write, PC unchanged, stk_ovf<=1.
REQ-035 Pop when sp==0: PC unchanged, stk_unf<=1.
REQ-036 On a stack error with HALT_ON_ERR=1, enter HALT; otherwise continue sequentially.
REQ-037 HALT: imem_en=0, instr_out=NOP; exit only via err_clr or reset.
REQ-038 In FLUSH: PC holds, pc_op/reti ignored, interrupts deferred.
REQ-039 Stall: all state holds; irq_ack stays 0.
REQ-040 err_clr together with a new error in the same cycle: the error wins.

Reset
REQ-041 On rst low, asynchronously: PC=0, sp=0, FSM=RUN, in_isr=0, flags=0, irq_ack=0, flush count=0; stack contents are don't-care.
REQ-042 Reset mid-FLUSH or mid-ISR aborts without residue; the first fetch after deassertion is from address 0.

Structure
REQ-043 pc_op encodings, FSM state encoding and defaults belong in the shared const package alongside TAM and N_IData.
REQ-044 The return stack is a sub-module, nrisc_ret_stack, providing push, pop, full, empty, top and count.

Verification
REQ-045 Reset, then 4 idle cycles -> imem_addr 0,1,2,3; imem_en=1.
REQ-046 At PC=5, call with tgt=0x40 -> sp=1, link_out=6, 2 NOP cycles, fetch 0x40; then return -> fetch 6, sp=0.
REQ-047 irq_req=8'b0010_0100 at PC=0x10 with irq_en=1 -> irq_ack=8'b0000_0100 for one cycle, PC=IRQ_BASE+2, in_isr=1; reti -> PC=0x10, in_isr=0.
REQ-048 17 nested calls with STACK_DEPTH=16 -> stk_ovf=1, HALT, instr_out=0; err_clr -> RUN.
REQ-049 Return with sp=0 -> stk_unf=1; simultaneous err_clr on the same cycle -> flag remains 1.
REQ-050 Assert rst during FLUSH with in_isr=1 -> all outputs at reset values; fetch resumes at 0.
